bpsk_modulator: RTL and testbench

BPSK_MODULATOR -- requirements
Module: bpsk_modulator

---
 rtl/bpsk_pkg.sv | 32 +++
 rtl/bpsk_modulator_if.sv | 13 +
 rtl/bpsk_modulator_pn_lfsr.sv | 29 ++
 rtl/bpsk_modulator.sv | 66 ++++++
 tb/tb_bpsk_modulator.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/bpsk_pkg.sv
// Shared constants for the BPSK modulator: default sizing, PN register
// geometry and the 64-point sine table (stored as one quarter wave).
package bpsk_pkg;

    localparam int              DFLT_CARRIER_LEN = 64;
    localparam int              DFLT_SYMBOL_LEN  = 1280;
    localparam int              SAMPLE_W         = 16;
    localparam int              LFSR_W           = 7;
    localparam logic [6:0]      DFLT_LFSR_SEED   = 7'h7F;
    localparam int              LFSR_TAP_A       = 6;
    localparam int              LFSR_TAP_B       = 5;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // round(32767*sin(2*pi*k/64)) for k = 0..16; the rest follows by symmetry
    localparam sample_t QTR_LUT [17] = '{
        16'sd0,     16'sd3212,  16'sd6393,  16'sd9512,
        16'sd12539, 16'sd15446, 16'sd18204, 16'sd20787,
        16'sd23170, 16'sd25329, 16'sd27245, 16'sd28898,
        16'sd30273, 16'sd31356, 16'sd32137, 16'sd32609,
        16'sd32767
    };

    function automatic sample_t sin_lut(input logic [5:0] k);
        logic [4:0] idx;
        sample_t    mag;
        idx = k[4] ? (5'd16 - {1'b0, k[3:0]}) : {1'b0, k[3:0]};
        mag = QTR_LUT[idx];
        return k[5] ? sample_t'(-mag) : mag;
    endfunction

endpackage

// File: rtl/bpsk_modulator_if.sv
// Sample-stream bundle between the modulator and its consumer.
interface bpsk_modulator_if;
    import bpsk_pkg::*;

    logic    en_p;
    sample_t carrier_sig;
    logic    m_sig;
    sample_t bpsk_sig;

    modport master (input en_p, output carrier_sig, output m_sig, output bpsk_sig);
    modport slave  (output en_p, input carrier_sig, input m_sig, input bpsk_sig);

endinterface

// File: rtl/bpsk_modulator_pn_lfsr.sv
// 7-bit Fibonacci PN generator (x^7+x^6+1); bit_out is the MSB and the
// register shifts left only on cycles where advance is high.
module pn_lfsr
    import bpsk_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DFLT_LFSR_SEED
) (
    input  logic clk_sig,
    input  logic rst_n,
    input  logic advance,
    output logic bit_out
);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (advance)
            lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]};
    end

    always_ff @(posedge clk_sig or negedge rst_n) begin
        if (!rst_n) lfsr_q <= SEED;
        else        lfsr_q <= lfsr_d;
    end

    assign bit_out = lfsr_q[LFSR_W-1];

endmodule

// File: rtl/bpsk_modulator.sv
// BPSK modulator: sine carrier from a table, PN data bit per symbol,
// and a registered mixer that flips carrier sign when the data bit is 0.
module bpsk_modulator
    import bpsk_pkg::*;
#(
    parameter int         CARRIER_LEN = DFLT_CARRIER_LEN,
    parameter int         SYMBOL_LEN  = DFLT_SYMBOL_LEN,
    parameter logic [6:0] LFSR_SEED   = DFLT_LFSR_SEED
) (
    input  logic    clk_sig,
    input  logic    rst_n,
    input  logic    en_p,
    output sample_t carrier_sig,
    output logic    m_sig,
    output sample_t bpsk_sig
);

    localparam int CNT_W = $clog2(SYMBOL_LEN);
    localparam int PH_W  = $clog2(CARRIER_LEN);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    sample_t          carrier_q, carrier_d;
    sample_t          bpsk_q, bpsk_d;
    logic             m_q, m_d;
    logic             sym_start;
    logic             pn_bit;

    // Symbol boundaries coincide with carrier phase 0 because SYMBOL_LEN
    // is a whole number of carrier periods and both derive from cnt.
    assign sym_start = (cnt_q == '0);

    pn_lfsr #(.SEED(LFSR_SEED)) u_pn (
        .clk_sig (clk_sig),
        .rst_n   (rst_n),
        .advance (sym_start),
        .bit_out (pn_bit)
    );

    always_comb begin
        cnt_d     = (cnt_q == CNT_W'(SYMBOL_LEN - 1)) ? '0 : cnt_q + 1'b1;
        carrier_d = sin_lut(6'(cnt_q[PH_W-1:0]));
        m_d       = sym_start ? pn_bit : m_q;
        bpsk_d    = '0;
        if (en_p)
            bpsk_d = m_q ? carrier_q : sample_t'(-carrier_q);
    end

    always_ff @(posedge clk_sig or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            carrier_q <= '0;
            m_q       <= 1'b0;
            bpsk_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            carrier_q <= carrier_d;
            m_q       <= m_d;
            bpsk_q    <= bpsk_d;
        end
    end

    assign carrier_sig = carrier_q;
    assign m_sig       = m_q;
    assign bpsk_sig    = bpsk_q;

endmodule

// File: tb/tb_bpsk_modulator.sv
// Scoreboard bench: stimulus predicts each edge from sin() and the PN
// recurrence; a monitor pops and compares. A short-symbol instance checks
// the full 127-symbol PN period.
module tb_bpsk_modulator;
    import bpsk_pkg::*;

    localparam int SYM  = 1280;
    localparam int SYM2 = 64;

    logic clk_sig = 1'b0;
    logic rst_n   = 1'b1;
    logic rst2_n  = 1'b1;

    bpsk_modulator_if bus ();
    bpsk_modulator_if bus2 ();

    bpsk_modulator #(.CARRIER_LEN(64), .SYMBOL_LEN(SYM), .LFSR_SEED(7'h7F)) dut (
        .clk_sig     (clk_sig),
        .rst_n       (rst_n),
        .en_p        (bus.en_p),
        .carrier_sig (bus.carrier_sig),
        .m_sig       (bus.m_sig),
        .bpsk_sig    (bus.bpsk_sig)
    );

    bpsk_modulator #(.CARRIER_LEN(64), .SYMBOL_LEN(SYM2), .LFSR_SEED(7'h7F)) dut_pn (
        .clk_sig     (clk_sig),
        .rst_n       (rst2_n),
        .en_p        (bus2.en_p),
        .carrier_sig (bus2.carrier_sig),
        .m_sig       (bus2.m_sig),
        .bpsk_sig    (bus2.bpsk_sig)
    );

    initial forever #5 clk_sig = ~clk_sig;

    typedef struct {
        int n;
        int car;
        int m;
        int bpsk;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   pn[127];
    int   phase   = 0;
    bit   done2   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_rng(input string name, input int act);
        n_total++;
        if (act >= -32767 && act <= 32767) n_pass++;
        else $display("FAIL %s: got %0d, expected within [-32767,32767]", name, act);
    endtask

    function automatic int ref_lut(input int k);
        real r;
        r = 32767.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 64.0);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    endfunction

    function automatic logic en_choice(input int n);
        if (phase == 1 && n >= 2000 && n < 2100) return 1'b0;
        if ((phase == 1 && n >= 4000 && n < 5000) || (phase == 2 && n >= 1000 && n < 2000))
            return 1'($urandom_range(0, 1));
        return 1'b1;
    endfunction

    task automatic spot(input int n);
        if (n == 1) begin
            chk("e1_carrier", bus.carrier_sig, 0);
            chk("e1_m", int'(bus.m_sig), 1);
        end
        if (n == 17) chk("e17_carrier", bus.carrier_sig, 32767);
        if (n == 18) chk("e18_bpsk", bus.bpsk_sig, 32767);
        if (phase == 1) begin
            if (n == 2050) chk("en_low_bpsk", bus.bpsk_sig, 0);
            if (n == 2100) chk("en_resume_bpsk", bus.bpsk_sig, -32137);
            if (n == 8961) chk("e8961_m", int'(bus.m_sig), 0);
            if (n == 8977) chk("e8977_carrier", bus.carrier_sig, 32767);
            if (n == 8978) chk("e8978_bpsk", bus.bpsk_sig, -32767);
        end
    endtask

    // Edge n counts rising edges since reset release; outputs after edge n
    // reflect carrier phase n-1 and symbol (n-1)/SYM.
    task automatic run(input int nedges);
        int pc = 0;
        int pm = 0;
        for (int n = 1; n <= nedges; n++) begin
            exp_t x;
            logic e;
            e = en_choice(n);
            bus.en_p = e;
            x.n    = n;
            x.car  = ref_lut((n - 1) % 64);
            x.m    = pn[((n - 1) / SYM) % 127];
            x.bpsk = e ? ((pm != 0) ? pc : -pc) : 0;
            q.push_back(x);
            pc = x.car;
            pm = x.m;
            @(posedge clk_sig);
            #1;
            spot(n);
            @(negedge clk_sig);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_sig);
            #1;
            if (q.size() > 0) begin
                exp_t x;
                x = q.pop_front();
                chk($sformatf("carrier@%0d", x.n), bus.carrier_sig, x.car);
                chk($sformatf("m@%0d", x.n), int'(bus.m_sig), x.m);
                chk($sformatf("bpsk@%0d", x.n), bus.bpsk_sig, x.bpsk);
                chk_rng($sformatf("bpsk_range@%0d", x.n), bus.bpsk_sig);
                chk_rng($sformatf("carrier_range@%0d", x.n), bus.carrier_sig);
            end
        end
    end

    initial begin
        int bits[254];
        int ones;
        int zw;
        bus2.en_p = 1'b1;
        #2 rst2_n = 1'b0;
        repeat (2) @(negedge clk_sig);
        rst2_n = 1'b1;
        for (int s = 0; s < 254; s++) begin
            for (int j = 0; j < SYM2; j++) begin
                @(posedge clk_sig);
                #1;
                if (j == 0) bits[s] = int'(bus2.m_sig);
            end
        end
        for (int i = 0; i < 254; i++) chk($sformatf("pn_bit%0d", i), bits[i], pn[i % 127]);
        for (int i = 0; i < 127; i++) chk($sformatf("pn_period%0d", i), bits[i + 127], bits[i]);
        ones = 0;
        for (int i = 0; i < 127; i++) ones += bits[i];
        chk("pn_ones", ones, 64);
        zw = 0;
        for (int i = 0; i + 7 <= 254; i++) begin
            int acc;
            acc = 0;
            for (int k = 0; k < 7; k++) acc += bits[i + k];
            if (acc == 0) zw++;
        end
        chk("pn_zero_state", zw, 0);
        done2 = 1'b1;
    end

    initial begin
        int guard;
        for (int i = 0; i < 127; i++) pn[i] = (i < 7) ? 1 : (pn[i - 7] ^ pn[i - 6]);
        bus.en_p = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk_sig);
        chk("rst_carrier", bus.carrier_sig, 0);
        chk("rst_m", int'(bus.m_sig), 0);
        chk("rst_bpsk", bus.bpsk_sig, 0);
        rst_n = 1'b1;
        phase = 1;
        run(9100);

        rst_n = 1'b0;
        #1;
        chk("rst1_carrier", bus.carrier_sig, 0);
        chk("rst1_m", int'(bus.m_sig), 0);
        chk("rst1_bpsk", bus.bpsk_sig, 0);
        repeat (2) @(negedge clk_sig);
        rst_n = 1'b1;
        phase = 2;
        run(5000);

        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_carrier", bus.carrier_sig, 0);
        chk("async_rst_m", int'(bus.m_sig), 0);
        chk("async_rst_bpsk", bus.bpsk_sig, 0);
        repeat (3) @(negedge clk_sig);
        rst_n = 1'b1;
        phase = 3;
        run(100);

        guard = 0;
        while (!done2 && guard < 30000) begin
            @(posedge clk_sig);
            guard++;
        end
        chk("pn_done", int'(done2), 1);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
